// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared opcodes, state encoding, datapath select encodings and per-state control decode
// for the multicycle RV32I control FSM.
package multicycle_ctrl_fsm_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_REGA = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_REGB = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b100;
    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       retire;
    } ctl_t;

    // Outputs that depend only on the state (op only selects the LW/SW immediate).
    function automatic ctl_t moore_ctl(input state_t s, input logic [6:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    c.mem_req = 1'b1;
            S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM;
                              c.imm_src = IMM_B; c.alu_op = ALUOP_ADD; end
            S_MEMADR:   begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD;
                              c.imm_src = (op == OP_SW) ? IMM_S : IMM_I; end
            S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; c.retire = 1'b1; end
            S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECR:    begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_REGB; c.alu_op = ALUOP_FUNCT; end
            S_EXECI:    begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_I;
                              c.alu_op = ALUOP_FUNCT; end
            S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; c.retire = 1'b1; end
            S_BEQ:      begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_REGB; c.alu_op = ALUOP_SUB;
                              c.result_src = RES_ALUOUT; c.branch = 1'b1; c.retire = 1'b1; end
            S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.alu_op = ALUOP_ADD;
                              c.result_src = RES_ALUOUT; c.pc_update = 1'b1; end
            S_JALR:     begin c.alu_src_a = SRCA_REGA; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_I;
                              c.alu_op = ALUOP_ADD; c.result_src = RES_ALURESULT; c.pc_update = 1'b1; end
            S_LUI:      begin c.alu_src_a = SRCA_ZERO; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_U;
                              c.alu_op = ALUOP_ADD; end
            S_AUIPC:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_U;
                              c.alu_op = ALUOP_ADD; end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/memory-handshake bundle between the multicycle FSM (master) and datapath/memory (slave).
// Optional illegal_insn signal exists only with MULTICYCLE_ILLEGAL_TRAP_EN.
interface multicycle_ctrl_fsm_if;
    logic [6:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [1:0] ALUOp;
    logic       instr_retire;
    logic       mem_timeout;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       illegal_insn;
`endif

    modport master (
        input  op, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, instr_retire, mem_timeout
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      , illegal_insn
`endif
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, instr_retire, mem_timeout
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      , illegal_insn
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Memory wait counter: counts cycles spent in a wait state without mem_ready and flags
// an abort when TIMEOUT is reached (TIMEOUT == 0 disables the abort).
module multicycle_ctrl_fsm_mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned WAIT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting_i,
    input  logic mem_ready_i,
    output logic timeout_o
);
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Clearing on any exit from waiting gives a fresh count on every wait-state entry.
    always_comb begin
        timeout_o = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_o = waiting_i && !mem_ready_i && (cnt_q == WAIT_W'(TIMEOUT));
        end
        cnt_d = (!waiting_i || mem_ready_i || timeout_o) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback with a
// variable-latency memory handshake. MULTICYCLE_ILLEGAL_TRAP_EN enables the illegal-opcode TRAP state.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned WAIT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master bus
);
    state_t state_q, state_d;
    ctl_t   ctl_q, ovl, ctl_o;
    logic   waiting, tmo;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    multicycle_ctrl_fsm_mem_wait_timer #(.TIMEOUT(TIMEOUT), .WAIT_W(WAIT_W)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .waiting_i   (waiting),
        .mem_ready_i (bus.mem_ready),
        .timeout_o   (tmo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    OP_AUIPC:     state_d = S_AUIPC;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB; else if (tmo) state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready || tmo) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctl_q   <= moore_ctl(S_FETCH, bus.op);
        end else begin
            state_q <= state_d;
            ctl_q   <= moore_ctl(state_d, bus.op);
        end
    end

    // Completion-cycle outputs ride on mem_ready; rst forces every output low.
    always_comb begin
        ovl = '0;
        if (state_q == S_FETCH && bus.mem_ready) begin
            ovl.ir_write   = 1'b1;
            ovl.pc_update  = 1'b1;
            ovl.alu_src_a  = SRCA_PC;
            ovl.alu_src_b  = SRCB_FOUR;
            ovl.alu_op     = ALUOP_ADD;
            ovl.result_src = RES_ALURESULT;
        end
        if (state_q == S_MEMWRITE && bus.mem_ready) ovl.retire = 1'b1;
        ctl_o = rst ? '0 : ctl_t'(ctl_q | ovl);
    end

    assign bus.mem_req      = ctl_o.mem_req;
    assign bus.AdrSrc       = ctl_o.adr_src;
    assign bus.IRWrite      = ctl_o.ir_write;
    assign bus.PCUpdate     = ctl_o.pc_update;
    assign bus.Branch       = ctl_o.branch;
    assign bus.RegWrite     = ctl_o.reg_write;
    assign bus.MemWrite     = ctl_o.mem_write;
    assign bus.ResultSrc    = ctl_o.result_src;
    assign bus.ALUSrcA      = ctl_o.alu_src_a;
    assign bus.ALUSrcB      = ctl_o.alu_src_b;
    assign bus.ImmSrc       = ctl_o.imm_src;
    assign bus.ALUOp        = ctl_o.alu_op;
    assign bus.instr_retire = ctl_o.retire;
    assign bus.mem_timeout  = !rst && tmo;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign bus.illegal_insn = !rst && (state_q == S_TRAP);
`endif
endmodule
